// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: execute unit has priority, debug port is forced in after STARVE_LIMIT denials.
// Latency: grants and memory strobes are combinational; debug read data returns exactly 1 cycle after grant.
// Backpressure: exe_stall holds the execute unit while debug owns the port; dbg_req is held until dbg_gnt.
module dmem_arbiter #(
    parameter int          STARVE_LIMIT = 8,
    parameter logic [11:0] MMIO_TOP     = 12'h008
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic        exe_rd,
    input  logic        exe_wr,
    input  logic [11:0] exe_addr,
    input  logic [7:0]  exe_wdata,
    output logic        exe_stall,
    input  logic        dbg_req,
    input  logic        dbg_wr,
    input  logic [11:0] dbg_addr,
    input  logic [7:0]  dbg_wdata,
    output logic        dbg_gnt,
    output logic        dbg_rvld,
    output logic [7:0]  dbg_rdata,
    output logic        mem_en,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [11:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RSP  = 1'b1
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state_q, state_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       rsp_mmio_q, rsp_mmio_d;

    logic exe_req;
    logic force_dbg;
    logic gnt;
    logic exe_sel;

    // Combinational outputs are qualified by reset_ so they drop the moment reset asserts.
    always_comb begin
        exe_req   = exe_rd | exe_wr;
        force_dbg = (starve_cnt_q == LIMIT);
        gnt       = reset_ & dbg_req & (~exe_req | force_dbg);
        exe_sel   = reset_ & exe_req & ~gnt;

        dbg_gnt   = gnt;
        exe_stall = exe_req & gnt;

        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = 12'h000;
        mem_wdata = 8'h00;
        if (gnt) begin
            mem_rd    = ~dbg_wr;
            mem_wr    = dbg_wr;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end else if (exe_sel) begin
            mem_rd    = exe_rd & ~exe_wr;
            mem_wr    = exe_wr;
            mem_addr  = exe_addr;
            mem_wdata = exe_wdata;
        end
        mem_en = (mem_rd | mem_wr) & (mem_addr >= MMIO_TOP);
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!dbg_req || gnt) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q < LIMIT) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    // A read response is owed next cycle whenever a debug read is granted, from either state.
    always_comb begin
        state_d    = ST_IDLE;
        rsp_mmio_d = 1'b0;
        if (gnt && !dbg_wr) begin
            state_d    = ST_RSP;
            rsp_mmio_d = (dbg_addr < MMIO_TOP);
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q      <= ST_IDLE;
            starve_cnt_q <= 4'd0;
            rsp_mmio_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            rsp_mmio_q   <= rsp_mmio_d;
        end
    end

    // MMIO reads never touched memory, so their response data is forced to zero.
    always_comb begin
        dbg_rvld  = (state_q == ST_RSP);
        dbg_rdata = 8'h00;
        if (dbg_rvld && !rsp_mmio_q) begin
            dbg_rdata = mem_rdata;
        end
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8, meaning the number of consecutive denied debug-request cycles before a debug access is forced (range 1..15).
REQ-002 SHALL have parameter MMIO_TOP, default 12'h008, meaning addresses below this value are register-mapped and never reach memory.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset_, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port exe_rd, input, 1 bit: execute-unit read request.
REQ-006 SHALL have port exe_wr, input, 1 bit: execute-unit write request.
REQ-007 SHALL have port exe_addr, input, 12 bits: execute-unit address.
REQ-008 SHALL have port exe_wdata, input, 8 bits: execute-unit write data.
REQ-009 SHALL have port exe_stall, output, 1 bit: execute request not serviced this cycle; requester holds its request.
REQ-010 SHALL have port dbg_req, input, 1 bit: debug/loader request, held until granted.
REQ-011 SHALL have port dbg_wr, input, 1 bit: 1 = write, 0 = read.
REQ-012 SHALL have port dbg_addr, input, 12 bits: debug address.
REQ-013 SHALL have port dbg_wdata, input, 8 bits: debug write data.
REQ-014 SHALL have port dbg_gnt, output, 1 bit: debug access issued this cycle.
REQ-015 SHALL have port dbg_rvld, output, 1 bit: debug read data valid.
REQ-016 SHALL have port dbg_rdata, output, 8 bits: debug read data.
REQ-017 SHALL have port mem_en, output, 1 bit: memory enable.
REQ-018 SHALL have ports mem_rd and mem_wr, outputs, 1 bit each: memory read and write strobes.
REQ-019 SHALL have port mem_addr, output, 12 bits: memory address.
REQ-020 SHALL have port mem_wdata, output, 8 bits: memory write data.
REQ-021 SHALL have port mem_rdata, input, 8 bits: synchronous memory read data, valid one cycle after a read strobe.

Function
REQ-022 Request definitions: exe_req = exe_rd|exe_wr; exe_wr SHALL win if both exe_rd and exe_wr are asserted.
REQ-023 Default priority SHALL be execute over debug; dbg_gnt = dbg_req & (!exe_req | force), where force = (starve_cnt == STARVE_LIMIT).
REQ-024 exe_stall SHALL equal exe_req & dbg_gnt; it is combinational in the same cycle.
REQ-025 starve_cnt (4 bits) SHALL increment when dbg_req & !dbg_gnt, saturate at STARVE_LIMIT, and clear to 0 on dbg_gnt or when dbg_req is low.
REQ-026 Memory mux: the selected requester SHALL drive mem_addr, mem_wdata, mem_rd and mem_wr; when idle, mem_addr, mem_wdata, mem_rd and mem_wr SHALL be 0.
REQ-027 mem_en SHALL equal (mem_rd|mem_wr) & (mem_addr >= MMIO_TOP); MMIO accesses still produce grant, stall and rvld behaviour.
REQ-028 FSM states:
- IDLE -> RSP on dbg_gnt & !dbg_wr.
- RSP -> RSP on another debug read grant.
- RSP -> IDLE otherwise.
REQ-029 In RSP, dbg_rvld SHALL be 1 and dbg_rdata SHALL equal mem_rdata (0 if the read was MMIO); dbg_rdata SHALL be 0 whenever dbg_rvld is 0.
REQ-030 Arbitration in RSP SHALL be identical to IDLE, so back-to-back accesses are allowed; read latency is exactly 1 cycle.
REQ-031 A debug write SHALL complete in its grant cycle; no dbg_rvld is produced for it.

Reset
REQ-032 While reset_ = 0, regardless of clk: state = IDLE, starve_cnt = 0, dbg_rvld = 0, dbg_rdata = 0, dbg_gnt = 0, exe_stall = 0, and all mem_* outputs = 0.
REQ-033 If a debug read is in flight when reset asserts, it SHALL be discarded: no dbg_rvld is produced after reset deasserts.

Verification
REQ-034 Debug-only read: dbg_req=1, dbg_wr=0, dbg_addr=12'h100, memory[0x100]=8'hA5 -> dbg_gnt=1 and mem_en=1 in cycle N; dbg_rvld=1 and dbg_rdata=8'hA5 in cycle N+1.
REQ-035 Contention: exe_wr=1 continuously and dbg_req=1 continuously, STARVE_LIMIT=8 -> 8 execute-only cycles, then one cycle with dbg_gnt=1 and exe_stall=1, then starve_cnt=0 and execute resumes.
REQ-036 MMIO filter: exe_rd=1, exe_addr=12'h005 -> mem_rd=1, mem_en=0, exe_stall=0.
REQ-037 Back-to-back debug reads of 0x200 then 0x201 -> dbg_rvld held high for 2 cycles with the matching data each cycle.
REQ-038 Reset mid-read: assert reset_ in the cycle after a debug read grant -> dbg_rvld=0 and all outputs 0 immediately (asynchronously); state = IDLE after release.
